// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths, the NOP encoding and the per-edge action codes.
// Imported by program_counter and pipeline_stall_flush_ctrl.
package pipeline_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 8;
    localparam int REG_ADDR_W  = 2;

    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 8'h00;

    // One of these is chosen per clock edge; later entries win over earlier ones.
    typedef enum logic [1:0] {
        ACT_NORMAL = 2'd0,
        ACT_WAIT   = 2'd1,
        ACT_STALL  = 2'd2,
        ACT_FLUSH  = 2'd3
    } pipe_act_e;

endpackage

// File: rtl/program_counter.sv
// Fetch PC register: redirect load beats hold, hold beats the sequential increment.
// The increment wraps naturally at 2^ADDR_W.
module program_counter
    import pipeline_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              hold,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_inc;

    assign w_pc_inc = r_pc + ADDR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (load_en) begin
            r_pc <= load_val;
        end else if (!hold) begin
            r_pc <= w_pc_inc;
        end
    end

    assign pc       = r_pc;
    assign pc_plus1 = w_pc_inc;

endmodule

// File: rtl/pipeline_stall_flush_ctrl.sv
// Fetch-side stall/flush control: owns PC and IF/ID, raises ID_EX_Bubble, watches for stuck stalls.
// Optional build macro PIPE_PERF_CNT_EN adds saturating Stall_Count / Flush_Count outputs.
module pipeline_stall_flush_ctrl
    import pipeline_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                INSTR_W   = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(8'h00),
    parameter int                MAX_STALL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Stall,
    input  logic               Branch_Taken,
    input  logic [ADDR_W-1:0]  Branch_Target,
    input  logic [INSTR_W-1:0] Instr_In,
    input  logic               Instr_Valid,
    output logic [ADDR_W-1:0]  PC_Out,
    output logic [INSTR_W-1:0] IF_ID_Instr,
    output logic [ADDR_W-1:0]  IF_ID_PC_Plus1,
    output logic               IF_ID_Valid,
    output logic               ID_EX_Bubble,
    output logic               Stall_Timeout
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [15:0]        Stall_Count,
    output logic [15:0]        Flush_Count
`endif
);

    localparam int                 CNT_W       = $clog2(MAX_STALL + 2);
    localparam logic [CNT_W-1:0]   STALL_LIMIT = CNT_W'(MAX_STALL + 1);
    localparam logic [INSTR_W-1:0] NOP_W       = INSTR_W'(NOP_INSTR);

    pipe_act_e          w_act;
    logic [ADDR_W-1:0]  w_pc;
    logic [ADDR_W-1:0]  w_pc_plus1;
    logic [CNT_W-1:0]   w_stall_cnt_nxt;

    logic [INSTR_W-1:0] r_if_id_instr;
    logic [ADDR_W-1:0]  r_if_id_pc_plus1;
    logic               r_if_id_valid;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               r_stall_timeout;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    // Branch redirect outranks the load-use stall: the stalled instruction is wrong-path anyway.
    always_comb begin
        w_act = ACT_NORMAL;
        if (Branch_Taken) begin
            w_act = ACT_FLUSH;
        end else if (Stall) begin
            w_act = ACT_STALL;
        end else if (!Instr_Valid) begin
            w_act = ACT_WAIT;
        end
    end

    assign ID_EX_Bubble = Branch_Taken | Stall;

    program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load_en  (w_act == ACT_FLUSH),
        .load_val (Branch_Target),
        .hold     ((w_act == ACT_STALL) || (w_act == ACT_WAIT)),
        .pc       (w_pc),
        .pc_plus1 (w_pc_plus1)
    );

    // IF/ID stage register; squash and fetch-wait both load a clean NOP bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_id_instr    <= NOP_W;
            r_if_id_pc_plus1 <= '0;
            r_if_id_valid    <= 1'b0;
        end else begin
            case (w_act)
                ACT_NORMAL: begin
                    r_if_id_instr    <= Instr_In;
                    r_if_id_pc_plus1 <= w_pc_plus1;
                    r_if_id_valid    <= 1'b1;
                end
                ACT_FLUSH, ACT_WAIT: begin
                    r_if_id_instr    <= NOP_W;
                    r_if_id_pc_plus1 <= '0;
                    r_if_id_valid    <= 1'b0;
                end
                default: begin
                    r_if_id_instr    <= r_if_id_instr;
                    r_if_id_pc_plus1 <= r_if_id_pc_plus1;
                    r_if_id_valid    <= r_if_id_valid;
                end
            endcase
        end
    end

    // Watchdog: the timeout must rise on the same edge the count reaches its limit.
    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        case (w_act)
            ACT_STALL:  w_stall_cnt_nxt = (r_stall_cnt == STALL_LIMIT) ? r_stall_cnt
                                                                       : r_stall_cnt + CNT_W'(1);
            ACT_FLUSH,
            ACT_NORMAL: w_stall_cnt_nxt = '0;
            default:    w_stall_cnt_nxt = r_stall_cnt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt     <= '0;
            r_stall_timeout <= 1'b0;
        end else begin
            r_stall_cnt     <= w_stall_cnt_nxt;
            r_stall_timeout <= r_stall_timeout | (w_stall_cnt_nxt == STALL_LIMIT);
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_act == ACT_STALL) r_stall_count <= sat_inc16(r_stall_count);
            if (w_act == ACT_FLUSH) r_flush_count <= sat_inc16(r_flush_count);
        end
    end

    assign Stall_Count = r_stall_count;
    assign Flush_Count = r_flush_count;
`endif

    assign PC_Out         = w_pc;
    assign IF_ID_Instr    = r_if_id_instr;
    assign IF_ID_PC_Plus1 = r_if_id_pc_plus1;
    assign IF_ID_Valid    = r_if_id_valid;
    assign Stall_Timeout  = r_stall_timeout;

endmodule

// File: tb/tb_pipeline_stall_flush_ctrl.sv
// Directed bench for pipeline_stall_flush_ctrl: vector table plus watchdog and async-reset sequences.
module tb_pipeline_stall_flush_ctrl;

    logic       clk;
    logic       rst;
    logic       Stall;
    logic       Branch_Taken;
    logic [7:0] Branch_Target;
    logic [7:0] Instr_In;
    logic       Instr_Valid;
    logic [7:0] PC_Out;
    logic [7:0] IF_ID_Instr;
    logic [7:0] IF_ID_PC_Plus1;
    logic       IF_ID_Valid;
    logic       ID_EX_Bubble;
    logic       Stall_Timeout;
`ifdef PIPE_PERF_CNT_EN
    logic [15:0] Stall_Count;
    logic [15:0] Flush_Count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    pipeline_stall_flush_ctrl #(
        .ADDR_W    (8),
        .INSTR_W   (8),
        .RESET_PC  (8'h00),
        .MAX_STALL (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .Stall          (Stall),
        .Branch_Taken   (Branch_Taken),
        .Branch_Target  (Branch_Target),
        .Instr_In       (Instr_In),
        .Instr_Valid    (Instr_Valid),
        .PC_Out         (PC_Out),
        .IF_ID_Instr    (IF_ID_Instr),
        .IF_ID_PC_Plus1 (IF_ID_PC_Plus1),
        .IF_ID_Valid    (IF_ID_Valid),
        .ID_EX_Bubble   (ID_EX_Bubble),
        .Stall_Timeout  (Stall_Timeout)
`ifdef PIPE_PERF_CNT_EN
        ,
        .Stall_Count    (Stall_Count),
        .Flush_Count    (Flush_Count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       stall;
        logic       br;
        logic [7:0] tgt;
        logic [7:0] instr;
        logic       ivld;
        logic [7:0] exp_pc;
        logic [7:0] exp_instr;
        logic [7:0] exp_pp1;
        logic       chk_pp1;
        logic       exp_valid;
        logic       exp_bub;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic b, input logic [7:0] t,
                         input logic [7:0] ins, input logic iv);
        Stall         = s;
        Branch_Taken  = b;
        Branch_Target = t;
        Instr_In      = ins;
        Instr_Valid   = iv;
    endtask

    // Apply inputs after negedge, check outputs #1 after the following posedge.
    task automatic step_chk(input string tag, input logic s, input logic [7:0] exp_pc,
                            input logic [7:0] exp_instr, input logic exp_to);
        @(negedge clk);
        drive(s, 1'b0, 8'h00, exp_instr, 1'b1);
        #1 check({tag, ".bubble"}, 32'(ID_EX_Bubble), 32'(s));
        @(posedge clk);
        #1;
        check({tag, ".pc"}, 32'(PC_Out), 32'(exp_pc));
        check({tag, ".instr"}, 32'(IF_ID_Instr), 32'(exp_instr));
        check({tag, ".timeout"}, 32'(Stall_Timeout), 32'(exp_to));
    endtask

    initial begin
        //          stall br  tgt    instr  ivld pc     instr  pp1    chk  vld  bub
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 8'h11, 1'b1, 8'h01, 8'h11, 8'h01, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 8'h22, 1'b1, 8'h02, 8'h22, 8'h02, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 8'h33, 1'b1, 8'h03, 8'h33, 8'h03, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 8'h44, 1'b1, 8'h04, 8'h44, 8'h04, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 8'h55, 1'b1, 8'h05, 8'h55, 8'h05, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 8'h66, 1'b1, 8'h05, 8'h55, 8'h05, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 8'h66, 1'b1, 8'h06, 8'h66, 8'h06, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 8'h06, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 8'h77, 1'b1, 8'h07, 8'h77, 8'h07, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 8'h40, 8'h78, 1'b1, 8'h40, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 8'h88, 1'b1, 8'h41, 8'h88, 8'h41, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 8'hFF, 8'h89, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 8'h99, 1'b1, 8'h00, 8'h99, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 8'hFF, 8'h9A, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 8'h10, 8'h9B, 1'b1, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 8'hAA, 1'b1, 8'h11, 8'hAA, 8'h11, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        #2;
        check("rst.pc", 32'(PC_Out), 32'h00);
        check("rst.instr", 32'(IF_ID_Instr), 32'h00);
        check("rst.pp1", 32'(IF_ID_PC_Plus1), 32'h00);
        check("rst.valid", 32'(IF_ID_Valid), 32'h0);
        check("rst.timeout", 32'(Stall_Timeout), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].instr, vecs[i].ivld);
            #1 check($sformatf("v%0d.bubble", i), 32'(ID_EX_Bubble), 32'(vecs[i].exp_bub));
            @(posedge clk);
            #1;
            check($sformatf("v%0d.pc", i), 32'(PC_Out), 32'(vecs[i].exp_pc));
            check($sformatf("v%0d.instr", i), 32'(IF_ID_Instr), 32'(vecs[i].exp_instr));
            check($sformatf("v%0d.valid", i), 32'(IF_ID_Valid), 32'(vecs[i].exp_valid));
            if (vecs[i].chk_pp1)
                check($sformatf("v%0d.pp1", i), 32'(IF_ID_PC_Plus1), 32'(vecs[i].exp_pp1));
            check($sformatf("v%0d.timeout", i), 32'(Stall_Timeout), 32'h0);
        end

        // Exactly MAX_STALL consecutive stalls must not trip the watchdog.
        for (int k = 0; k < 4; k++) step_chk($sformatf("s4_%0d", k), 1'b1, 8'h11, 8'hAA, 1'b0);
        step_chk("s4_rel", 1'b0, 8'h12, 8'hBB, 1'b0);

        // MAX_STALL+1 stalls trip it on the fifth edge; it stays set afterwards.
        for (int k = 0; k < 5; k++) step_chk($sformatf("s5_%0d", k), 1'b1, 8'h12, 8'hBB, (k == 4));
        step_chk("s5_rel", 1'b0, 8'h13, 8'hCC, 1'b1);
        step_chk("s5_stay", 1'b0, 8'h14, 8'hDD, 1'b1);

`ifdef PIPE_PERF_CNT_EN
        check("perf.stall", 32'(Stall_Count), 32'd10);
        check("perf.flush", 32'(Flush_Count), 32'd4);
`endif

        // Asynchronous reset in the middle of a stall.
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h00, 8'hEE, 1'b1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst.pc", 32'(PC_Out), 32'h00);
        check("arst.instr", 32'(IF_ID_Instr), 32'h00);
        check("arst.pp1", 32'(IF_ID_PC_Plus1), 32'h00);
        check("arst.valid", 32'(IF_ID_Valid), 32'h0);
        check("arst.timeout", 32'(Stall_Timeout), 32'h0);
`ifdef PIPE_PERF_CNT_EN
        check("arst.stall_cnt", 32'(Stall_Count), 32'd0);
        check("arst.flush_cnt", 32'(Flush_Count), 32'd0);
`endif
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        rst = 1'b0;
        step_chk("post_rst", 1'b0, 8'h01, 8'h21, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
